// File: rtl/vx_barrier_unit_pkg.sv
// Shared widths, request types and small helpers for the barrier unit.
package vx_barrier_unit_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 4;
  localparam int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int CNT_WIDTH    = NW_WIDTH + 1;
  localparam int GQ_DEPTH     = 2;

  // Barrier command as issued by warp control at commit.
  typedef struct packed {
    logic                valid;
    logic [NW_WIDTH-1:0] wid;
    logic [NB_WIDTH-1:0] id;
    logic [NW_WIDTH-1:0] size_m1;
    logic                is_global;
  } barrier_t;

  // Arrival request sent to the global barrier network.
  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
  } gbar_req_t;

  // One-hot warp mask for a warp id.
  function automatic logic [NUM_WARPS-1:0] wid_to_mask(input logic [NW_WIDTH-1:0] wid);
    logic [NUM_WARPS-1:0] one;
    one = {{(NUM_WARPS-1){1'b0}}, 1'b1};
    return one << wid;
  endfunction

endpackage

// File: rtl/vx_barrier_unit_entry.sv
// One local barrier: arrival count plus mask of waiting warps.
// A kill is applied before the arrival of the same cycle, so the arrival
// sees the purged count when deciding whether to release.
module vx_barrier_unit_entry
  import vx_barrier_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive_valid,
  input  logic [NW_WIDTH-1:0]  arrive_wid,
  input  logic [NW_WIDTH-1:0]  arrive_size_m1,
  input  logic                 kill_valid,
  input  logic [NW_WIDTH-1:0]  kill_wid,
  output logic                 release_flag,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic [NUM_WARPS-1:0] stall_set,
  output logic                 dup_flag
);

  logic [CNT_WIDTH-1:0] count_q, count_d, count_k;
  logic [NUM_WARPS-1:0] wait_q, wait_d, wait_k;
  logic [NUM_WARPS-1:0] arrive_bit;
  logic [CNT_WIDTH-1:0] size_ext;
  logic                 kill_hit;

  // Purge a killed warp, then resolve the arrival: duplicate, release or wait.
  always_comb begin
    kill_hit     = kill_valid && wait_q[kill_wid];
    arrive_bit   = wid_to_mask(arrive_wid);
    size_ext     = {1'b0, arrive_size_m1};
    release_flag = 1'b0;
    release_mask = '0;
    stall_set    = '0;
    dup_flag     = 1'b0;
    if (kill_hit) begin
      wait_k  = wait_q & ~wid_to_mask(kill_wid);
      count_k = count_q - CNT_WIDTH'(1);
    end else begin
      wait_k  = wait_q;
      count_k = count_q;
    end
    count_d = count_k;
    wait_d  = wait_k;
    if (arrive_valid) begin
      if ((wait_k & arrive_bit) != '0) begin
        dup_flag = 1'b1;
      end else if (count_k == size_ext) begin
        release_flag = 1'b1;
        release_mask = wait_k | arrive_bit;
        count_d      = CNT_WIDTH'(0);
        wait_d       = '0;
      end else begin
        count_d   = count_k + CNT_WIDTH'(1);
        wait_d    = wait_k | arrive_bit;
        stall_set = arrive_bit;
      end
    end else begin
      dup_flag = 1'b0;
    end
  end

  // Count and wait-mask state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= CNT_WIDTH'(0);
      wait_q  <= '0;
    end else begin
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: rtl/vx_barrier_unit.sv
// Barrier unit: local barrier table, global barrier forwarding with a
// one-deep request register backed by a 2-entry FIFO, and the per-warp
// stall mask / release event seen by the scheduler.
module vx_barrier_unit
  import vx_barrier_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [NW_WIDTH-1:0]  req_wid,
  input  logic [NB_WIDTH-1:0]  req_id,
  input  logic [NW_WIDTH-1:0]  req_size_m1,
  input  logic                 req_is_global,
  output logic                 gbar_req_valid,
  output logic [NB_WIDTH-1:0]  gbar_req_id,
  input  logic                 gbar_req_ready,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_WIDTH-1:0]  gbar_rsp_id,
  input  logic                 wkill_valid,
  input  logic [NW_WIDTH-1:0]  wkill_wid,
  output logic [NUM_WARPS-1:0] stalled,
  output logic                 release_valid,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic                 dup_error
);

  barrier_t req;
  assign req.valid     = req_valid;
  assign req.wid       = req_wid;
  assign req.id        = req_id;
  assign req.size_m1   = req_size_m1;
  assign req.is_global = req_is_global;

  // A kill and an arrival of the same warp in one cycle: the kill wins.
  logic arr_ok, local_arr, glob_arr;
  assign arr_ok    = req.valid && !(wkill_valid && (wkill_wid == req.wid));
  assign local_arr = arr_ok && !req.is_global;
  assign glob_arr  = arr_ok && req.is_global;

  logic [NUM_BARRIERS-1:0]                ent_arrive, ent_rel, ent_dup;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] ent_rel_mask, ent_set;

  genvar g;
  generate
    for (g = 0; g < NUM_BARRIERS; g++) begin : g_entry
      assign ent_arrive[g] = local_arr && (req.id == NB_WIDTH'(g));
      vx_barrier_unit_entry u_entry (
        .clk            (clk),
        .reset          (reset),
        .arrive_valid   (ent_arrive[g]),
        .arrive_wid     (req.wid),
        .arrive_size_m1 (req.size_m1),
        .kill_valid     (wkill_valid),
        .kill_wid       (wkill_wid),
        .release_flag   (ent_rel[g]),
        .release_mask   (ent_rel_mask[g]),
        .stall_set      (ent_set[g]),
        .dup_flag       (ent_dup[g])
      );
    end
  endgenerate

  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] gwait_q, gwait_d;
  logic [NUM_WARPS-1:0] stalled_q, stalled_d;
  logic [NUM_WARPS-1:0] release_mask_q, release_mask_d;
  logic                 release_valid_q, release_valid_d;
  logic                 dup_q, dup_d;
  logic [NUM_WARPS-1:0] kill_bit, req_bit, local_rel, local_set, glob_rel, glob_set, gw;

  // Merge local releases, global responses, new waits and kills.
  always_comb begin
    kill_bit  = wkill_valid ? wid_to_mask(wkill_wid) : '0;
    req_bit   = wid_to_mask(req.wid);
    glob_set  = glob_arr ? req_bit : '0;
    local_rel = '0;
    local_set = '0;
    glob_rel  = '0;
    gwait_d   = gwait_q;
    for (int e = 0; e < NUM_BARRIERS; e++) begin
      local_rel = local_rel | ent_rel_mask[e];
      local_set = local_set | ent_set[e];
      gw = gwait_q[e] & ~kill_bit;
      if (gbar_rsp_valid && (gbar_rsp_id == NB_WIDTH'(e))) begin
        glob_rel = glob_rel | gw;
        gw       = '0;
      end else begin
        glob_rel = glob_rel;
      end
      if (glob_arr && (req.id == NB_WIDTH'(e))) begin
        gw = gw | req_bit;
      end else begin
        gw = gw;
      end
      gwait_d[e] = gw;
    end
    release_mask_d  = local_rel | glob_rel;
    release_valid_d = (|ent_rel) | (|glob_rel);
    stalled_d       = (stalled_q | local_set | glob_set) & ~release_mask_d & ~kill_bit;
    dup_d           = dup_q | (|ent_dup);
  end

  gbar_req_t                    greg_q, greg_d, push_entry;
  logic                         greg_valid_q, greg_valid_d;
  gbar_req_t [GQ_DEPTH-1:0]     gfifo_q, gfifo_d;
  logic [1:0]                   gcnt_q, gcnt_d;
  logic                         gfire, greg_free;

  // Global request register refilled from the FIFO first, then from a new arrival.
  always_comb begin
    push_entry.id = req.id;
    gfire         = greg_valid_q && gbar_req_ready;
    greg_free     = !greg_valid_q || gfire;
    greg_valid_d  = greg_valid_q;
    greg_d        = greg_q;
    gfifo_d       = gfifo_q;
    gcnt_d        = gcnt_q;
    if (greg_free) begin
      if (gcnt_q != 2'd0) begin
        greg_valid_d = 1'b1;
        greg_d       = gfifo_q[0];
        gfifo_d[0]   = gfifo_q[1];
        gcnt_d       = gcnt_q - 2'd1;
        if (glob_arr) begin
          if (gcnt_q == 2'd1) begin
            gfifo_d[0] = push_entry;
          end else begin
            gfifo_d[1] = push_entry;
          end
          gcnt_d = gcnt_q;
        end else begin
          gcnt_d = gcnt_q - 2'd1;
        end
      end else if (glob_arr) begin
        greg_valid_d = 1'b1;
        greg_d       = push_entry;
      end else begin
        greg_valid_d = 1'b0;
      end
    end else begin
      if (glob_arr && (gcnt_q < 2'd2)) begin
        if (gcnt_q == 2'd0) begin
          gfifo_d[0] = push_entry;
        end else begin
          gfifo_d[1] = push_entry;
        end
        gcnt_d = gcnt_q + 2'd1;
      end else begin
        gcnt_d = gcnt_q;
      end
    end
  end

  // All unit state; outputs come straight from these flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gwait_q         <= '0;
      stalled_q       <= '0;
      release_mask_q  <= '0;
      release_valid_q <= 1'b0;
      dup_q           <= 1'b0;
      greg_q          <= '0;
      greg_valid_q    <= 1'b0;
      gfifo_q         <= '0;
      gcnt_q          <= 2'd0;
    end else begin
      gwait_q         <= gwait_d;
      stalled_q       <= stalled_d;
      release_mask_q  <= release_mask_d;
      release_valid_q <= release_valid_d;
      dup_q           <= dup_d;
      greg_q          <= greg_d;
      greg_valid_q    <= greg_valid_d;
      gfifo_q         <= gfifo_d;
      gcnt_q          <= gcnt_d;
    end
  end

  assign stalled        = stalled_q;
  assign release_valid  = release_valid_q;
  assign release_mask   = release_mask_q;
  assign dup_error      = dup_q;
  assign gbar_req_valid = greg_valid_q;
  assign gbar_req_id    = greg_q.id;

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Self-checking bench for vx_barrier_unit: directed scenarios plus random
// traffic, compared against a behavioural barrier model.
module tb_vx_barrier_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_is_global;
  logic [1:0] req_wid, req_id, req_size_m1;
  logic       gbar_req_valid, gbar_req_ready;
  logic [1:0] gbar_req_id;
  logic       gbar_rsp_valid;
  logic [1:0] gbar_rsp_id;
  logic       wkill_valid;
  logic [1:0] wkill_wid;
  logic [3:0] stalled, release_mask;
  logic       release_valid, dup_error;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  int         m_cnt[4];
  logic [3:0] m_wait[4];
  logic [3:0] m_gwait[4];
  logic [3:0] m_stalled, m_rel;
  logic       m_dup;
  int         gq[$];
  int         sizes[4];

  vx_barrier_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_wid        (req_wid),
    .req_id         (req_id),
    .req_size_m1    (req_size_m1),
    .req_is_global  (req_is_global),
    .gbar_req_valid (gbar_req_valid),
    .gbar_req_id    (gbar_req_id),
    .gbar_req_ready (gbar_req_ready),
    .gbar_rsp_valid (gbar_rsp_valid),
    .gbar_rsp_id    (gbar_rsp_id),
    .wkill_valid    (wkill_valid),
    .wkill_wid      (wkill_wid),
    .stalled        (stalled),
    .release_valid  (release_valid),
    .release_mask   (release_mask),
    .dup_error      (dup_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < 4; e++) begin
      m_cnt[e] = 0; m_wait[e] = 4'b0000; m_gwait[e] = 4'b0000;
    end
    m_stalled = 4'b0000; m_rel = 4'b0000; m_dup = 1'b0;
    gq.delete();
  endtask

  task automatic clear_inputs();
    req_valid = 1'b0; req_is_global = 1'b0; req_wid = 2'd0; req_id = 2'd0; req_size_m1 = 2'd0;
    gbar_rsp_valid = 1'b0; gbar_rsp_id = 2'd0; wkill_valid = 1'b0; wkill_wid = 2'd0;
  endtask

  // Apply the barrier rules to the current inputs, clock once, compare outputs.
  task automatic step();
    logic [3:0] kb, rel, nset, b;
    bit fire, push;
    kb   = wkill_valid ? (4'b0001 << wkill_wid) : 4'b0000;
    rel  = 4'b0000; nset = 4'b0000; push = 1'b0;
    fire = (gq.size() != 0) && gbar_req_ready;
    if (wkill_valid) begin
      for (int e = 0; e < 4; e++) begin
        if (m_wait[e][wkill_wid]) begin
          m_wait[e][wkill_wid] = 1'b0;
          m_cnt[e] = m_cnt[e] - 1;
        end
        m_gwait[e] = m_gwait[e] & ~kb;
      end
    end
    if (gbar_rsp_valid) begin
      rel = rel | m_gwait[gbar_rsp_id];
      m_gwait[gbar_rsp_id] = 4'b0000;
    end
    if (req_valid && !(wkill_valid && wkill_wid == req_wid)) begin
      b = 4'b0001 << req_wid;
      if (req_is_global) begin
        m_gwait[req_id] = m_gwait[req_id] | b;
        nset = nset | b;
        push = 1'b1;
      end else if ((m_wait[req_id] & b) != 4'b0000) begin
        m_dup = 1'b1;
      end else if (m_cnt[req_id] == int'(req_size_m1)) begin
        rel = rel | m_wait[req_id] | b;
        m_cnt[req_id] = 0;
        m_wait[req_id] = 4'b0000;
      end else begin
        m_cnt[req_id] = m_cnt[req_id] + 1;
        m_wait[req_id] = m_wait[req_id] | b;
        nset = nset | b;
      end
    end
    if (fire) void'(gq.pop_front());
    if (push) gq.push_back(int'(req_id));
    m_stalled = (m_stalled | nset) & ~rel & ~kb;
    m_rel = rel;
    @(posedge clk);
    #1;
    check_val("stalled", stalled, m_stalled);
    check_val("release_valid", release_valid, (m_rel != 4'b0000));
    check_val("release_mask", release_mask, m_rel);
    check_val("dup_error", dup_error, m_dup);
    check_val("gbar_req_valid", gbar_req_valid, (gq.size() != 0));
    if (gq.size() != 0) check_val("gbar_req_id", gbar_req_id, gq[0]);
  endtask

  task automatic arrive(input int wid, input int id, input int sm1, input bit glob);
    clear_inputs();
    req_valid = 1'b1; req_wid = 2'(wid); req_id = 2'(id);
    req_size_m1 = 2'(sm1); req_is_global = glob;
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    gbar_req_ready = 1'b0;
    model_reset();
    reset = 1'b1;
    #12;
    check_val("rst_stalled", stalled, 4'b0000);
    check_val("rst_release", {release_valid, release_mask}, 5'b00000);
    check_val("rst_gbar", gbar_req_valid, 1'b0);
    check_val("rst_dup", dup_error, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: four-warp local barrier on id 1.
    arrive(0, 1, 3, 1'b0); arrive(1, 1, 3, 1'b0); arrive(2, 1, 3, 1'b0);
    check_val("t1_stalled", stalled, 4'b0111);
    arrive(3, 1, 3, 1'b0);
    check_val("t1_release", release_mask, 4'b1111);
    check_val("t1_stalled_clr", stalled, 4'b0000);
    step();

    // 2: single-warp self release.
    arrive(2, 0, 0, 1'b0);
    check_val("t2_release", release_mask, 4'b0100);
    check_val("t2_stalled", stalled, 4'b0000);

    // 3: duplicate arrival leaves the count untouched.
    arrive(1, 2, 2, 1'b0); arrive(1, 2, 2, 1'b0);
    check_val("t3_dup", dup_error, 1'b1);
    check_val("t3_no_rel", release_valid, 1'b0);
    arrive(0, 2, 2, 1'b0); arrive(3, 2, 2, 1'b0);
    check_val("t3_release", release_mask, 4'b1011);

    // 4: two global arrivals held off by the network, then released.
    gbar_req_ready = 1'b0;
    arrive(0, 3, 0, 1'b1); arrive(2, 3, 0, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check_val("t4_held", gbar_req_valid, 1'b1);
    gbar_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_val("t4_drained", gbar_req_valid, 1'b0);
    gbar_req_ready = 1'b0;
    gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'd3;
    step(); clear_inputs();
    check_val("t4_release", release_mask, 4'b0101);

    // 5: kill a waiting warp, the barrier still completes with the rest.
    arrive(0, 0, 2, 1'b0); arrive(1, 0, 2, 1'b0);
    wkill_valid = 1'b1; wkill_wid = 2'd1;
    step(); clear_inputs();
    check_val("t5_stalled", stalled, 4'b0001);
    check_val("t5_kill_no_rel", release_valid, 1'b0);
    arrive(2, 0, 2, 1'b0); arrive(3, 0, 2, 1'b0);
    check_val("t5_release", release_mask, 4'b1101);

    // 6: local release and global response merged, then async reset.
    gbar_req_ready = 1'b1;
    arrive(0, 0, 1, 1'b0); arrive(3, 1, 0, 1'b1);
    req_valid = 1'b1; req_wid = 2'd1; req_id = 2'd0; req_size_m1 = 2'd1;
    gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'd1;
    step(); clear_inputs();
    check_val("t6_release", release_mask, 4'b1011);
    arrive(2, 2, 3, 1'b0);
    check_val("t6_wait", stalled, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check_val("t6_rst_stalled", stalled, 4'b0000);
    check_val("t6_rst_release", {release_valid, release_mask}, 5'b00000);
    check_val("t6_rst_dup", dup_error, 1'b0);
    check_val("t6_rst_gbar", gbar_req_valid, 1'b0);
    model_reset();
    #3 reset = 1'b0;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 4; i++) sizes[i] = $urandom_range(0, 3);
    for (int c = 0; c < 600; c++) begin
      int w;
      clear_inputs();
      gbar_req_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        wkill_valid = 1'b1; wkill_wid = 2'($urandom_range(0, 3));
      end
      w = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1 && !m_stalled[w]) begin
        req_valid = 1'b1; req_wid = 2'(w); req_id = 2'($urandom_range(0, 3));
        req_size_m1 = 2'(sizes[req_id]);
        req_is_global = ($urandom_range(0, 3) == 0) && (gq.size() < 3);
      end
      if ($urandom_range(0, 4) == 0) begin
        gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
